// File: rtl/game_pkg.sv
// ============================================================================
// Module : game_pkg
// Brief  : Shared state codes, field widths and frog geometry defaults for the
//          lane-crossing game sequencer and animators.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int LIVES_W     = 3;
    localparam int LEVEL_W     = 3;
    localparam int SCORE_W     = 8;
    localparam int FROG_Y_W    = 12;
    localparam int FRAME_CNT_W = 16;

    localparam logic [2:0] ST_ATTRACT   = 3'd0;
    localparam logic [2:0] ST_PLAY      = 3'd1;
    localparam logic [2:0] ST_DYING     = 3'd2;
    localparam logic [2:0] ST_RESPAWN   = 3'd3;
    localparam logic [2:0] ST_LEVEL_UP  = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    typedef enum logic [2:0] {
        S_ATTRACT   = ST_ATTRACT,
        S_PLAY      = ST_PLAY,
        S_DYING     = ST_DYING,
        S_RESPAWN   = ST_RESPAWN,
        S_LEVEL_UP  = ST_LEVEL_UP,
        S_GAME_OVER = ST_GAME_OVER
    } state_t;

    // Frog geometry shared with the frog animator
    localparam int FROG_SPAWN_X   = 312;
    localparam int FROG_SPAWN_Y   = 440;
    localparam int GOAL_Y_DEFAULT = 30;

    function automatic logic freeze_of(input state_t s);
        return !((s == S_PLAY) || (s == S_RESPAWN));
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// Module : frame_timer
// Brief  : Loadable down-counter of end-of-frame pulses; o_done flags the pulse
//          that takes the count to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_timer
    import game_pkg::*;
#(
    parameter int W = FRAME_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_animate,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_animate && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Fires on the last pulse so the state change lands on the same edge
    assign o_done = i_animate && (r_cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module : game_ctrl
// Brief  : Game sequencer: attract, play, death, respawn, level-up, game-over.
//          Optional extra-life on even levels via GAME_CTRL_EXTRA_LIFE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int MAX_LIVES      = 7,
    parameter int GOAL_Y         = GOAL_Y_DEFAULT,
    parameter int DEATH_FRAMES   = 60,
    parameter int RESPAWN_FRAMES = 30,
    parameter int LEVELUP_FRAMES = 45,
    parameter int MAX_LEVEL      = 7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_animate,
    input  logic                i_hit,
    input  logic [FROG_Y_W-1:0] i_frog_y1,
    input  logic                i_start,
    output logic [2:0]          o_state,
    output logic [LIVES_W-1:0]  o_lives,
    output logic [LEVEL_W-1:0]  o_level,
    output logic [SCORE_W-1:0]  o_score,
    output logic [2:0]          o_speed,
    output logic                o_freeze,
    output logic                o_frog_rst
);

    localparam logic [FROG_Y_W-1:0] c_GOAL_Y      = FROG_Y_W'(GOAL_Y);
    localparam logic [LEVEL_W-1:0]  c_MAX_LEVEL   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0]  c_MAX_LIVES   = LIVES_W'(MAX_LIVES);
    // Guards against a start count configured above the ceiling
    localparam logic [LIVES_W-1:0]  c_START_LIVES =
        (LIVES > MAX_LIVES) ? LIVES_W'(MAX_LIVES) : LIVES_W'(LIVES);

    state_t               r_state;
    logic [LIVES_W-1:0]   r_lives;
    logic [LEVEL_W-1:0]   r_level;
    logic [SCORE_W-1:0]   r_score;
    logic [2:0]           r_speed;
    logic                 r_freeze;
    logic                 r_frog_rst;
    logic                 r_armed;

    logic                   w_goal;
    logic                   w_start_go;
    logic                   w_tmr_done;
    logic                   w_tmr_load;
    logic [FRAME_CNT_W-1:0] w_tmr_val;
    logic [LEVEL_W-1:0]     w_level_next;
    logic [SCORE_W:0]       w_score_sum;

    assign w_goal       = (i_frog_y1 < c_GOAL_Y);
    assign w_start_go   = i_start && ((r_state == S_ATTRACT) ||
                                      ((r_state == S_GAME_OVER) && r_armed));
    assign w_level_next = (r_level >= c_MAX_LEVEL) ? r_level : r_level + 1'b1;
    assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(r_level) + 1'b1;

    // Timer reload mirrors every transition into a timed state
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            S_PLAY: begin
                if (i_hit) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = FRAME_CNT_W'(DEATH_FRAMES);
                end else if (w_goal) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = FRAME_CNT_W'(LEVELUP_FRAMES);
                end
            end
            S_DYING: begin
                if (w_tmr_done && (r_lives != '0)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = FRAME_CNT_W'(RESPAWN_FRAMES);
                end
            end
            default: ;
        endcase
    end

    frame_timer #(.W(FRAME_CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_animate  (i_animate),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_ATTRACT;
            r_lives    <= '0;
            r_level    <= '0;
            r_score    <= '0;
            r_speed    <= 3'd1;
            r_freeze   <= 1'b1;
            r_frog_rst <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_frog_rst <= 1'b0;
            // Level 7 would need speed 8; the 3-bit lane speed tops out at 7
            r_speed    <= (r_level == '1) ? 3'd7 : 3'(r_level) + 3'd1;

            case (r_state)
                S_ATTRACT, S_GAME_OVER: begin
                    if (!i_start) begin
                        r_armed <= 1'b1;
                    end
                    if (w_start_go) begin
                        r_lives    <= c_START_LIVES;
                        r_level    <= '0;
                        r_score    <= '0;
                        r_frog_rst <= 1'b1;
                        r_state    <= S_PLAY;
                        r_freeze   <= freeze_of(S_PLAY);
                    end
                end
                S_PLAY: begin
                    if (i_hit) begin
                        if (r_lives != '0) begin
                            r_lives <= r_lives - 1'b1;
                        end
                        r_state  <= S_DYING;
                        r_freeze <= freeze_of(S_DYING);
                    end else if (w_goal) begin
                        r_score    <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                        r_frog_rst <= 1'b1;
                        r_state    <= S_LEVEL_UP;
                        r_freeze   <= freeze_of(S_LEVEL_UP);
                    end
                end
                S_DYING: begin
                    if (w_tmr_done) begin
                        if (r_lives == '0) begin
                            r_armed  <= 1'b0;
                            r_state  <= S_GAME_OVER;
                            r_freeze <= freeze_of(S_GAME_OVER);
                        end else begin
                            r_frog_rst <= 1'b1;
                            r_state    <= S_RESPAWN;
                            r_freeze   <= freeze_of(S_RESPAWN);
                        end
                    end
                end
                S_RESPAWN: begin
                    if (w_tmr_done) begin
                        r_state  <= S_PLAY;
                        r_freeze <= freeze_of(S_PLAY);
                    end
                end
                S_LEVEL_UP: begin
                    if (w_tmr_done) begin
                        r_level  <= w_level_next;
`ifdef GAME_CTRL_EXTRA_LIFE_EN
                        if (!w_level_next[0] && (r_lives < c_MAX_LIVES)) begin
                            r_lives <= r_lives + 1'b1;
                        end
`endif
                        r_state  <= S_PLAY;
                        r_freeze <= freeze_of(S_PLAY);
                    end
                end
                default: begin
                    r_state  <= S_ATTRACT;
                    r_freeze <= freeze_of(S_ATTRACT);
                end
            endcase
        end
    end

    assign o_state    = r_state;
    assign o_lives    = r_lives;
    assign o_level    = r_level;
    assign o_score    = r_score;
    assign o_speed    = r_speed;
    assign o_freeze   = r_freeze;
    assign o_frog_rst = r_frog_rst;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module : tb_game_ctrl
// Brief  : Directed self-checking bench for game_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        animate;
    logic        hit;
    logic [11:0] frog_y1;
    logic        start;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [2:0]  level;
    logic [7:0]  score;
    logic [2:0]  speed;
    logic        freeze;
    logic        frog_rst;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lives;

    always #5 clk = ~clk;

    game_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_animate  (animate),
        .i_hit      (hit),
        .i_frog_y1  (frog_y1),
        .i_start    (start),
        .o_state    (state),
        .o_lives    (lives),
        .o_level    (level),
        .o_score    (score),
        .o_speed    (speed),
        .o_freeze   (freeze),
        .o_frog_rst (frog_rst)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            animate = 1'b1;
            cyc();
            animate = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; animate = 1'b0; hit = 1'b0; frog_y1 = 12'd200; start = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        n_tests++; if (state !== 3'd0)  begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
        n_tests++; if (lives !== 3'd0)  begin n_fail++; $display("FAIL rst_lives got %0d exp 0", lives); end
        n_tests++; if (level !== 3'd0)  begin n_fail++; $display("FAIL rst_level got %0d exp 0", level); end
        n_tests++; if (score !== 8'd0)  begin n_fail++; $display("FAIL rst_score got %0d exp 0", score); end
        n_tests++; if (speed !== 3'd1)  begin n_fail++; $display("FAIL rst_speed got %0d exp 1", speed); end
        n_tests++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL rst_freeze got %0b exp 1", freeze); end
        n_tests++; if (frog_rst !== 1'b0) begin n_fail++; $display("FAIL rst_frog_rst got %0b exp 0", frog_rst); end
    endtask

    task automatic test_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_tests++; if (state !== 3'd1)    begin n_fail++; $display("FAIL start_state got %0d exp 1", state); end
        n_tests++; if (lives !== 3'd3)    begin n_fail++; $display("FAIL start_lives got %0d exp 3", lives); end
        n_tests++; if (frog_rst !== 1'b1) begin n_fail++; $display("FAIL start_frog_rst got %0b exp 1", frog_rst); end
        n_tests++; if (freeze !== 1'b0)   begin n_fail++; $display("FAIL start_freeze got %0b exp 0", freeze); end
        cyc();
        n_tests++; if (frog_rst !== 1'b0) begin n_fail++; $display("FAIL start_pulse_width got %0b exp 0", frog_rst); end
        exp_lives = 3;
    endtask

    task automatic test_death();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        n_tests++; if (state !== 3'd2)  begin n_fail++; $display("FAIL hit_state got %0d exp 2", state); end
        n_tests++; if (lives !== 3'd2)  begin n_fail++; $display("FAIL hit_lives got %0d exp 2", lives); end
        n_tests++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL hit_freeze got %0b exp 1", freeze); end
        frames(59);
        n_tests++; if (state !== 3'd2)  begin n_fail++; $display("FAIL dying59_state got %0d exp 2", state); end
        frames(1);
        n_tests++; if (state !== 3'd3)    begin n_fail++; $display("FAIL dying60_state got %0d exp 3", state); end
        n_tests++; if (frog_rst !== 1'b1) begin n_fail++; $display("FAIL respawn_frog_rst got %0b exp 1", frog_rst); end
        n_tests++; if (freeze !== 1'b0)   begin n_fail++; $display("FAIL respawn_freeze got %0b exp 0", freeze); end
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL respawn_hit_state got %0d exp 3", state); end
        n_tests++; if (lives !== 3'd2) begin n_fail++; $display("FAIL respawn_hit_lives got %0d exp 2", lives); end
        frames(29);
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL respawn29_state got %0d exp 3", state); end
        frames(1);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL respawn30_state got %0d exp 1", state); end
        exp_lives = 2;
    endtask

    task automatic test_goal();
        frog_y1 = 12'd30;
        cyc();
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL goal_edge30_state got %0d exp 1", state); end
        frog_y1 = 12'd20;
        cyc();
        frog_y1 = 12'd200;
        n_tests++; if (state !== 3'd4)    begin n_fail++; $display("FAIL goal_state got %0d exp 4", state); end
        n_tests++; if (score !== 8'd1)    begin n_fail++; $display("FAIL goal_score got %0d exp 1", score); end
        n_tests++; if (frog_rst !== 1'b1) begin n_fail++; $display("FAIL goal_frog_rst got %0b exp 1", frog_rst); end
        frames(44);
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL lvl44_state got %0d exp 4", state); end
        frames(1);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL lvl45_state got %0d exp 1", state); end
        n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL lvl45_level got %0d exp 1", level); end
        n_tests++; if (speed !== 3'd1) begin n_fail++; $display("FAIL speed_latency got %0d exp 1", speed); end
        cyc();
        n_tests++; if (speed !== 3'd2) begin n_fail++; $display("FAIL speed_follow got %0d exp 2", speed); end
        frog_y1 = 12'd20;
        cyc();
        frog_y1 = 12'd200;
        n_tests++; if (score !== 8'd3) begin n_fail++; $display("FAIL goal2_score got %0d exp 3", score); end
        frames(45);
`ifdef GAME_CTRL_EXTRA_LIFE_EN
        exp_lives = 3;
`else
        exp_lives = 2;
`endif
        n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL goal2_level got %0d exp 2", level); end
        n_tests++; if (lives !== 3'(exp_lives)) begin n_fail++; $display("FAIL goal2_lives got %0d exp %0d", lives, exp_lives); end
    endtask

    task automatic test_hit_and_goal();
        hit = 1'b1; frog_y1 = 12'd20;
        cyc();
        hit = 1'b0; frog_y1 = 12'd200;
        exp_lives = exp_lives - 1;
        n_tests++; if (state !== 3'd2) begin n_fail++; $display("FAIL both_state got %0d exp 2", state); end
        n_tests++; if (score !== 8'd3) begin n_fail++; $display("FAIL both_score got %0d exp 3", score); end
        n_tests++; if (lives !== 3'(exp_lives)) begin n_fail++; $display("FAIL both_lives got %0d exp %0d", lives, exp_lives); end
        frames(60);
        frames(30);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL both_back_state got %0d exp 1", state); end
    endtask

    task automatic test_game_over();
        for (int i = 1; i < exp_lives; i++) begin
            hit = 1'b1; cyc(); hit = 1'b0;
            frames(60);
            frames(30);
        end
        hit = 1'b1; cyc(); hit = 1'b0;
        n_tests++; if (lives !== 3'd0) begin n_fail++; $display("FAIL last_lives got %0d exp 0", lives); end
        start = 1'b1;
        frames(60);
        n_tests++; if (state !== 3'd5)    begin n_fail++; $display("FAIL over_state got %0d exp 5", state); end
        n_tests++; if (freeze !== 1'b1)   begin n_fail++; $display("FAIL over_freeze got %0b exp 1", freeze); end
        n_tests++; if (frog_rst !== 1'b0) begin n_fail++; $display("FAIL over_frog_rst got %0b exp 0", frog_rst); end
        repeat (5) cyc();
        n_tests++; if (state !== 3'd5) begin n_fail++; $display("FAIL over_held_state got %0d exp 5", state); end
        start = 1'b0;
        cyc();
        n_tests++; if (state !== 3'd5) begin n_fail++; $display("FAIL over_low_state got %0d exp 5", state); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_tests++; if (state !== 3'd1)    begin n_fail++; $display("FAIL restart_state got %0d exp 1", state); end
        n_tests++; if (lives !== 3'd3)    begin n_fail++; $display("FAIL restart_lives got %0d exp 3", lives); end
        n_tests++; if (score !== 8'd0)    begin n_fail++; $display("FAIL restart_score got %0d exp 0", score); end
        n_tests++; if (level !== 3'd0)    begin n_fail++; $display("FAIL restart_level got %0d exp 0", level); end
        n_tests++; if (frog_rst !== 1'b1) begin n_fail++; $display("FAIL restart_frog_rst got %0b exp 1", frog_rst); end
    endtask

    task automatic test_saturation();
        // Level-ups add 1..7, then 8 each at the level ceiling
        for (int i = 0; i < 8; i++) begin
            frog_y1 = 12'd20; cyc(); frog_y1 = 12'd200;
            frames(45);
        end
        n_tests++; if (level !== 3'd7)  begin n_fail++; $display("FAIL level_sat got %0d exp 7", level); end
        n_tests++; if (score !== 8'd36) begin n_fail++; $display("FAIL score_36 got %0d exp 36", score); end
`ifdef GAME_CTRL_EXTRA_LIFE_EN
        exp_lives = 6;
`else
        exp_lives = 3;
`endif
        n_tests++; if (lives !== 3'(exp_lives)) begin n_fail++; $display("FAIL sat_lives got %0d exp %0d", lives, exp_lives); end
        for (int i = 0; i < 27; i++) begin
            frog_y1 = 12'd20; cyc(); frog_y1 = 12'd200;
            frames(45);
        end
        n_tests++; if (score !== 8'd252) begin n_fail++; $display("FAIL score_252 got %0d exp 252", score); end
        frog_y1 = 12'd20; cyc(); frog_y1 = 12'd200;
        n_tests++; if (score !== 8'd255) begin n_fail++; $display("FAIL score_sat got %0d exp 255", score); end
        frames(45);
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL sat_back_state got %0d exp 1", state); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; start = 1'b1;
        cyc();
        n_tests++; if (state !== 3'd0)    begin n_fail++; $display("FAIL mrst_state got %0d exp 0", state); end
        n_tests++; if (lives !== 3'd0)    begin n_fail++; $display("FAIL mrst_lives got %0d exp 0", lives); end
        n_tests++; if (score !== 8'd0)    begin n_fail++; $display("FAIL mrst_score got %0d exp 0", score); end
        n_tests++; if (level !== 3'd0)    begin n_fail++; $display("FAIL mrst_level got %0d exp 0", level); end
        n_tests++; if (speed !== 3'd1)    begin n_fail++; $display("FAIL mrst_speed got %0d exp 1", speed); end
        n_tests++; if (freeze !== 1'b1)   begin n_fail++; $display("FAIL mrst_freeze got %0b exp 1", freeze); end
        cyc();
        n_tests++; if (frog_rst !== 1'b0) begin n_fail++; $display("FAIL mrst_frog_rst got %0b exp 0", frog_rst); end
        rst = 1'b0; start = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_goal();
        test_hit_and_goal();
        test_game_over();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
